// File: rtl/estagio_wb_if.sv
// Write-back stage bus: result inputs from execute/memory, read ports
// and the registered write-back view.
interface estagio_wb_if #(
  parameter int LARGURA = 16,
  parameter int N_REGS  = 8
);
  localparam int AW = $clog2(N_REGS);

  logic               valido_in;
  logic [LARGURA-1:0] Saida_ULA;
  logic [LARGURA-1:0] Saida_MemoriaDados;
  logic               sel_wb;
  logic               BR_Hab_Escrita;
  logic [AW-1:0]      reg_destino;
  logic [AW-1:0]      endA;
  logic [AW-1:0]      endB;
  logic [LARGURA-1:0] A;
  logic [LARGURA-1:0] B;
  logic [LARGURA-1:0] dado_wb;
  logic [AW-1:0]      reg_wb;
  logic               valido_wb;
  logic [15:0]        contador_escritas;

  modport master (
    output valido_in, Saida_ULA, Saida_MemoriaDados,
    output sel_wb, BR_Hab_Escrita, reg_destino,
    output endA, endB,
    input  A, B, dado_wb, reg_wb, valido_wb,
    input  contador_escritas
  );

  modport slave (
    input  valido_in, Saida_ULA, Saida_MemoriaDados,
    input  sel_wb, BR_Hab_Escrita, reg_destino,
    input  endA, endB,
    output A, B, dado_wb, reg_wb, valido_wb,
    output contador_escritas
  );
endinterface

// File: rtl/estagio_wb.sv
// Write-back stage: result mux register, register bank with
// combinational bypassed reads and a committed-write counter.
module estagio_wb #(
  parameter int LARGURA = 16,
  parameter int N_REGS  = 8
) (
  input logic         clock,
  input logic         reset,
  estagio_wb_if.slave bus
);
  localparam int AW = $clog2(N_REGS);

  logic [LARGURA-1:0] banco [N_REGS];
  logic [LARGURA-1:0] dado_q;
  logic [AW-1:0]      reg_q;
  logic               val_q;
  logic [15:0]        cnt_q;
  logic [LARGURA-1:0] rd_a;
  logic [LARGURA-1:0] rd_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dado_q <= '0;
      reg_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      dado_q <= bus.sel_wb ? bus.Saida_MemoriaDados
                           : bus.Saida_ULA;
      reg_q  <= bus.reg_destino;
      val_q  <= bus.valido_in & bus.BR_Hab_Escrita
              & (bus.reg_destino != '0);
    end
  end

  // Address 0 never commits, so banco[0] stays at its reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REGS; i++) begin
        banco[i] <= '0;
      end
      cnt_q <= '0;
    end else if (val_q) begin
      banco[reg_q] <= dado_q;
      cnt_q        <= cnt_q + 16'd1;
    end
  end

  always_comb begin
    rd_a = banco[bus.endA];
    unique case (1'b1)
      (bus.endA == '0):                 rd_a = '0;
      (val_q && (reg_q == bus.endA)):   rd_a = dado_q;
      default: ;
    endcase
  end

  always_comb begin
    rd_b = banco[bus.endB];
    unique case (1'b1)
      (bus.endB == '0):                 rd_b = '0;
      (val_q && (reg_q == bus.endB)):   rd_b = dado_q;
      default: ;
    endcase
  end

  assign bus.A                 = rd_a;
  assign bus.B                 = rd_b;
  assign bus.dado_wb           = dado_q;
  assign bus.reg_wb            = reg_q;
  assign bus.valido_wb         = val_q;
  assign bus.contador_escritas = cnt_q;
endmodule

// File: tb/tb_estagio_wb.sv
// Bench for estagio_wb: directed table, async reset sequence,
// random traffic against a reference model, counter wrap.
module tb_estagio_wb;
  logic clock;
  logic reset;
  int   total;
  int   bad;

  estagio_wb_if #(.LARGURA(16), .N_REGS(8)) bus ();

  estagio_wb #(.LARGURA(16), .N_REGS(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        v;
    logic        sel;
    logic        hab;
    logic [2:0]  dest;
    logic [15:0] ula;
    logic [15:0] mem;
    logic [2:0]  ea;
    logic [2:0]  eb;
    logic [15:0] x_dado;
    logic        x_val;
    logic [15:0] x_a;
    logic [15:0] x_b;
    logic [15:0] x_cnt;
  } vec_t;

  vec_t tbl [8];

  // reference model state
  logic [15:0] mbank [8];
  logic        p_v;
  logic [2:0]  p_a;
  logic [15:0] p_d;
  int          mcnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic hab,
                       input logic [2:0] dest, input logic [15:0] ula,
                       input logic [15:0] mem, input logic [2:0] ea,
                       input logic [2:0] eb);
    bus.valido_in          = v;
    bus.sel_wb             = sel;
    bus.BR_Hab_Escrita     = hab;
    bus.reg_destino        = dest;
    bus.Saida_ULA          = ula;
    bus.Saida_MemoriaDados = mem;
    bus.endA               = ea;
    bus.endB               = eb;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] mread(input logic [2:0] e);
    if (e == 3'd0) return 16'h0;
    if (p_v && p_a == e) return p_d;
    return mbank[e];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mbank[i] = 16'h0;
    p_v = 1'b0; p_a = 3'd0; p_d = 16'h0; mcnt = 0;
  endtask

  task automatic model_edge();
    if (p_v) begin
      mbank[p_a] = p_d;
      mcnt = (mcnt + 1) % 65536;
    end
    p_v = bus.valido_in && bus.BR_Hab_Escrita && (bus.reg_destino != 0);
    p_a = bus.reg_destino;
    p_d = bus.sel_wb ? bus.Saida_MemoriaDados : bus.Saida_ULA;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    //      v  sel hab dest ula      mem      ea  eb   dado     val A        B        cnt
    tbl[0] = '{1, 0, 1, 3, 16'h1234, 16'h0000, 3, 0, 16'h1234, 1, 16'h1234, 16'h0000, 16'd0};
    tbl[1] = '{0, 0, 0, 0, 16'h0000, 16'h0000, 3, 5, 16'h0000, 0, 16'h1234, 16'h0000, 16'd1};
    tbl[2] = '{1, 1, 1, 5, 16'h0000, 16'hBEEF, 3, 5, 16'hBEEF, 1, 16'h1234, 16'hBEEF, 16'd1};
    tbl[3] = '{1, 0, 1, 0, 16'hFFFF, 16'h0000, 0, 5, 16'hFFFF, 0, 16'h0000, 16'hBEEF, 16'd2};
    tbl[4] = '{1, 0, 1, 7, 16'h0001, 16'h0000, 7, 7, 16'h0001, 1, 16'h0001, 16'h0001, 16'd2};
    tbl[5] = '{1, 0, 1, 7, 16'h0002, 16'h0000, 7, 7, 16'h0002, 1, 16'h0002, 16'h0002, 16'd3};
    tbl[6] = '{0, 0, 1, 7, 16'h0055, 16'h0000, 7, 7, 16'h0055, 0, 16'h0002, 16'h0002, 16'd4};
    tbl[7] = '{1, 0, 0, 3, 16'h9999, 16'h0000, 3, 0, 16'h9999, 0, 16'h1234, 16'h0000, 16'd4};

    reset = 1'b1;
    drive(1, 0, 1, 3, 16'h7777, 16'h8888, 3, 3);
    #3;
    chk("rst_dado", bus.dado_wb, 16'h0);
    chk("rst_reg", bus.reg_wb, 3'd0);
    chk("rst_val", bus.valido_wb, 1'b0);
    chk("rst_cnt", bus.contador_escritas, 16'h0);
    chk("rst_A", bus.A, 16'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].hab, tbl[i].dest,
            tbl[i].ula, tbl[i].mem, tbl[i].ea, tbl[i].eb);
      tick();
      chk($sformatf("t%0d_dado", i), bus.dado_wb, tbl[i].x_dado);
      chk($sformatf("t%0d_reg", i), bus.reg_wb, tbl[i].dest);
      chk($sformatf("t%0d_val", i), bus.valido_wb, tbl[i].x_val);
      chk($sformatf("t%0d_A", i), bus.A, tbl[i].x_a);
      chk($sformatf("t%0d_B", i), bus.B, tbl[i].x_b);
      chk($sformatf("t%0d_cnt", i), bus.contador_escritas, tbl[i].x_cnt);
    end

    // asynchronous reset while a write is pending
    drive(1, 0, 1, 2, 16'hAAAA, 16'h0, 2, 2);
    tick();
    chk("ar_pend_val", bus.valido_wb, 1'b1);
    chk("ar_pend_A", bus.A, 16'hAAAA);
    #2 reset = 1'b1;
    #1;
    chk("ar_dado", bus.dado_wb, 16'h0);
    chk("ar_reg", bus.reg_wb, 3'd0);
    chk("ar_val", bus.valido_wb, 1'b0);
    chk("ar_cnt", bus.contador_escritas, 16'h0);
    chk("ar_A", bus.A, 16'h0);
    chk("ar_B", bus.B, 16'h0);
    tick();
    reset = 1'b0;
    drive(1, 0, 1, 4, 16'h4444, 16'h0, 2, 3);
    tick();
    chk("ar_first_dado", bus.dado_wb, 16'h4444);
    chk("ar_first_val", bus.valido_wb, 1'b1);
    chk("ar_bank2", bus.A, 16'h0);
    chk("ar_bank3", bus.B, 16'h0);
    chk("ar_cnt2", bus.contador_escritas, 16'h0);

    // random traffic
    reset = 1'b1;
    #2 reset = 1'b0;
    model_clear();
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1),
            ($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)),
            16'($urandom), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #1;
      chk("rnd_A", bus.A, mread(bus.endA));
      chk("rnd_B", bus.B, mread(bus.endB));
      model_edge();
      tick();
      chk("rnd_dado", bus.dado_wb, p_d);
      chk("rnd_val", bus.valido_wb, p_v);
      chk("rnd_cnt", bus.contador_escritas, 16'(mcnt));
    end

    // counter wrap
    reset = 1'b1;
    #2 reset = 1'b0;
    drive(1, 0, 1, 1, 16'h0, 16'h0, 1, 0);
    for (int n = 0; n < 65536; n++) begin
      bus.Saida_ULA = 16'($urandom);
      tick();
    end
    chk("wrap_ffff", bus.contador_escritas, 16'hFFFF);
    tick();
    chk("wrap_0000", bus.contador_escritas, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
